// File: rtl/multi_timer_pkg.sv
// Shared register map, CTRL bit positions and channel FSM states for multi_timer.
// The CTRL read-back packing lives here so that the field layout is defined in one place.
package multi_timer_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_IE   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2
  } chan_state_e;

  function automatic logic [31:0] ctrl_word(input logic en, input logic mode, input logic ie);
    return {28'd0, ie, 1'b0, mode, en};
  endfunction

endpackage

// File: rtl/multi_timer_channel.sv
// One down-counting timer channel: CTRL/PRESET registers, IDLE/LOAD/CNT FSM,
// sticky pending flag and registered interrupt.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             tick,
  input  logic             we_ctrl,
  input  logic             we_preset,
  input  logic             we_status,
  input  logic [CNT_W-1:0] wd,
  output logic             en,
  output logic             mode,
  output logic             ie,
  output logic [CNT_W-1:0] preset,
  output logic [CNT_W-1:0] count,
  output logic             pend,
  output logic             irq
);

  chan_state_e      state_r;
  chan_state_e      state_nxt_s;
  logic             en_r;
  logic             mode_r;
  logic             ie_r;
  logic             pend_r;
  logic             irq_r;
  logic [CNT_W-1:0] preset_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             freeze_s;
  logic             en_wr_s;
  logic             step_s;
  logic             expire_s;

  // A CTRL/PRESET write freezes LOAD/CNT for the cycle; IDLE looks at the incoming EN
  // so that the enabling write itself starts the load.
  assign freeze_s = we_ctrl | we_preset;
  assign en_wr_s  = we_ctrl ? wd[CTRL_EN] : en_r;
  assign step_s   = (state_r == CNT) && !freeze_s && en_r && tick;
  assign expire_s = step_s && (count_r <= CNT_W'(1));

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (en_wr_s) state_nxt_s = LOAD;
        else         state_nxt_s = IDLE;
      end
      LOAD: begin
        if (freeze_s) state_nxt_s = LOAD;
        else          state_nxt_s = CNT;
      end
      CNT: begin
        if (freeze_s)                 state_nxt_s = CNT;
        else if (!en_r)               state_nxt_s = IDLE;
        else if (expire_s && !mode_r) state_nxt_s = IDLE;
        else                          state_nxt_s = CNT;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Counter update; expiry lands on 0 (one-shot) or reloads PRESET (auto-reload).
  always_comb begin
    count_nxt_s = count_r;
    case (state_r)
      LOAD: begin
        if (freeze_s) count_nxt_s = count_r;
        else          count_nxt_s = preset_r;
      end
      CNT: begin
        if (expire_s)    count_nxt_s = mode_r ? preset_r : {CNT_W{1'b0}};
        else if (step_s) count_nxt_s = count_r - CNT_W'(1);
        else             count_nxt_s = count_r;
      end
      default: count_nxt_s = count_r;
    endcase
  end

  // Bus-visible configuration; one-shot expiry drops EN.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      en_r     <= 1'b0;
      mode_r   <= 1'b0;
      ie_r     <= 1'b0;
      preset_r <= {CNT_W{1'b0}};
    end else begin
      if (we_ctrl) begin
        en_r   <= wd[CTRL_EN];
        mode_r <= wd[CTRL_MODE];
        ie_r   <= wd[CTRL_IE];
      end else if (expire_s && !mode_r) begin
        en_r <= 1'b0;
      end
      if (we_preset) preset_r <= wd;
    end
  end

  // Counter, sticky pending flag (expiry beats W1C) and registered interrupt.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      count_r <= {CNT_W{1'b0}};
      pend_r  <= 1'b0;
      irq_r   <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      if (expire_s)                pend_r <= 1'b1;
      else if (we_status && wd[0]) pend_r <= 1'b0;
      irq_r <= pend_r & ie_r;
    end
  end

  assign en     = en_r;
  assign mode   = mode_r;
  assign ie     = ie_r;
  assign preset = preset_r;
  assign count  = count_r;
  assign pend   = pend_r;
  assign irq    = irq_r;

endmodule

// File: rtl/multi_timer.sv
// N_CH independent timer channels behind one word-addressed bus slave, with a shared
// prescaler, combinational read mux and a registered OR-reduced interrupt.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter  int N_CH     = 2,
  parameter  int CNT_W    = 32,
  parameter  int PRESCALE = 1,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [CH_W+1:0] ADDR,
  input  logic            WE,
  input  logic [31:0]     WD,
  output logic [31:0]     RD,
  output logic            IRQ,
  output logic [N_CH-1:0] IRQ_VEC
);

  logic [PS_W-1:0]  presc_r;
  logic             tick_s;
  logic             irq_r;
  logic [CH_W-1:0]  ch_s;
  logic [1:0]       reg_s;
  logic             ch_ok_s;
  logic [N_CH-1:0]  en_s;
  logic [N_CH-1:0]  mode_s;
  logic [N_CH-1:0]  ie_s;
  logic [N_CH-1:0]  pend_s;
  logic [N_CH-1:0]  irq_vec_s;
  logic [CNT_W-1:0] preset_s [N_CH];
  logic [CNT_W-1:0] count_s  [N_CH];
  logic [31:0]      rd_s;

  assign ch_s    = ADDR[CH_W+1:2];
  assign reg_s   = ADDR[1:0];
  assign ch_ok_s = ({{(32-CH_W){1'b0}}, ch_s} < 32'(N_CH));
  assign tick_s  = (presc_r == PS_W'(PRESCALE - 1));

  // Free-running prescaler shared by every channel.
  always_ff @(posedge CLK) begin
    if (!RST_N)      presc_r <= {PS_W{1'b0}};
    else if (tick_s) presc_r <= {PS_W{1'b0}};
    else             presc_r <= presc_r + PS_W'(1);
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic hit_s;
    assign hit_s = WE && ch_ok_s && (ch_s == CH_W'(i));

    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .tick     (tick_s),
      .we_ctrl  (hit_s && (reg_s == REG_CTRL)),
      .we_preset(hit_s && (reg_s == REG_PRESET)),
      .we_status(hit_s && (reg_s == REG_STATUS)),
      .wd       (WD[CNT_W-1:0]),
      .en       (en_s[i]),
      .mode     (mode_s[i]),
      .ie       (ie_s[i]),
      .preset   (preset_s[i]),
      .count    (count_s[i]),
      .pend     (pend_s[i]),
      .irq      (irq_vec_s[i])
    );
  end

  // Read mux; unimplemented channels read as zero.
  always_comb begin
    rd_s = 32'd0;
    if (ch_ok_s) begin
      case (reg_s)
        REG_CTRL:   rd_s = ctrl_word(en_s[ch_s], mode_s[ch_s], ie_s[ch_s]);
        REG_PRESET: rd_s = 32'(preset_s[ch_s]);
        REG_COUNT:  rd_s = 32'(count_s[ch_s]);
        REG_STATUS: rd_s = {31'd0, pend_s[ch_s]};
        default:    rd_s = 32'd0;
      endcase
    end else begin
      rd_s = 32'd0;
    end
  end

  // Same registered stage as the per-channel irq, so IRQ and IRQ_VEC rise together.
  always_ff @(posedge CLK) begin
    if (!RST_N) irq_r <= 1'b0;
    else        irq_r <= |(pend_s & ie_s);
  end

  assign RD      = rd_s;
  assign IRQ     = irq_r;
  assign IRQ_VEC = irq_vec_s;

endmodule

// File: tb/tb_multi_timer.sv
// Scoreboard bench for multi_timer: a PRESCALE=1 two-channel instance and a
// PRESCALE=4 three-channel instance (for prescaler phase and out-of-range decode).
module tb_multi_timer;
  import multi_timer_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [2:0]  addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;
  logic [1:0]  irq_vec;
  logic [3:0]  addr4;
  logic        we4;
  logic [31:0] wd4;
  logic [31:0] rd4;
  logic        irq4;
  logic [2:0]  irq_vec4;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb_q[$];
  logic [1:0]  ref_ps;

  always #5 CLK = ~CLK;

  multi_timer #(.N_CH(2), .CNT_W(32), .PRESCALE(1)) dut (
    .CLK(CLK), .RST_N(RST_N), .ADDR(addr), .WE(we), .WD(wd),
    .RD(rd), .IRQ(irq), .IRQ_VEC(irq_vec)
  );

  multi_timer #(.N_CH(3), .CNT_W(16), .PRESCALE(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .ADDR(addr4), .WE(we4), .WD(wd4),
    .RD(rd4), .IRQ(irq4), .IRQ_VEC(irq_vec4)
  );

  // Reference prescaler phase for the PRESCALE=4 instance (tick when it is 3 before the edge).
  always @(posedge CLK) begin
    if (!RST_N) ref_ps <= 2'd0;
    else        ref_ps <= ref_ps + 2'd1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [2:0] ad(input logic ch, input logic [1:0] r);
    return {ch, r};
  endfunction

  function automatic logic [3:0] ad4(input logic [1:0] ch, input logic [1:0] r);
    return {ch, r};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    addr = a; wd = d; we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic wr4(input logic [3:0] a, input logic [31:0] d);
    addr4 = a; wd4 = d; we4 = 1'b1;
    step();
    we4 = 1'b0;
  endtask

  task automatic rdr(input logic [2:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rd;
  endtask

  task automatic rdr4(input logic [3:0] a, output logic [31:0] d);
    addr4 = a;
    #1;
    d = rd4;
  endtask

  task automatic test_reset();
    logic [31:0] got, exp_v;
    RST_N = 1'b0; we = 1'b0; we4 = 1'b0;
    addr = 3'd0; addr4 = 4'd0; wd = 32'd0; wd4 = 32'd0;
    step(); step();
    RST_N = 1'b1;
    for (int ch = 0; ch < 2; ch++) begin
      for (int r = 0; r < 4; r++) begin
        sb_q.push_back(32'd0);
        rdr(ad(ch[0], r[1:0]), got);
        exp_v = sb_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL reset_reg ch%0d r%0d: got %0h want %0h", ch, r, got, exp_v); end
      end
      step();
    end
    sb_q.push_back(32'd0);
    exp_v = sb_q.pop_front(); checks++;
    if ({25'd0, irq, irq_vec, irq4, irq_vec4} !== exp_v) begin
      errors++; $display("FAIL reset_irq: got %b%b%b%b want 0", irq, irq_vec, irq4, irq_vec4);
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] got, exp_v;
    int p_first, v_first, i_first;
    p_first = -1; v_first = -1; i_first = -1;
    wr(ad(1'b0, REG_PRESET), 32'd3);
    wr(ad(1'b0, REG_CTRL), 32'h9);
    sb_q.push_back(32'd4); sb_q.push_back(32'd5); sb_q.push_back(32'd5);
    for (int k = 1; k <= 8; k++) begin
      step();
      rdr(ad(1'b0, REG_STATUS), got);
      if (got[0] && p_first < 0) p_first = k;
      if (irq_vec[0] && v_first < 0) v_first = k;
      if (irq && i_first < 0) i_first = k;
    end
    exp_v = sb_q.pop_front(); checks++;
    if (32'(p_first) !== exp_v) begin errors++; $display("FAIL oneshot_pend_edge: got %0d want %0d", p_first, exp_v); end
    exp_v = sb_q.pop_front(); checks++;
    if (32'(v_first) !== exp_v) begin errors++; $display("FAIL oneshot_irqvec_edge: got %0d want %0d", v_first, exp_v); end
    exp_v = sb_q.pop_front(); checks++;
    if (32'(i_first) !== exp_v) begin errors++; $display("FAIL oneshot_irq_edge: got %0d want %0d", i_first, exp_v); end
    sb_q.push_back(32'h8); sb_q.push_back(32'd0);
    rdr(ad(1'b0, REG_CTRL), got);
    exp_v = sb_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL oneshot_ctrl: got %0h want %0h", got, exp_v); end
    rdr(ad(1'b0, REG_COUNT), got);
    exp_v = sb_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL oneshot_count: got %0h want %0h", got, exp_v); end
    checks++;
    if (dut.g_ch[0].u_ch.state_r !== IDLE) begin errors++; $display("FAIL oneshot_state: got %0d want %0d", dut.g_ch[0].u_ch.state_r, IDLE); end
    wr(ad(1'b0, REG_STATUS), 32'd1);
  endtask

  task automatic test_autoreload();
    logic [31:0] got, exp_v;
    wr(ad(1'b1, REG_PRESET), 32'd2);
    wr(ad(1'b1, REG_CTRL), 32'hB);
    for (int k = 1; k <= 2; k++) begin
      step();
      sb_q.push_back((k % 2 == 1) ? 32'd2 : 32'd1);
      rdr(ad(1'b1, REG_COUNT), got);
      exp_v = sb_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL reload_count k%0d: got %0d want %0d", k, got, exp_v); end
    end
    // Edge 3 is an expiry edge: the clear must lose.
    wr(ad(1'b1, REG_STATUS), 32'd1);
    sb_q.push_back(32'd1); sb_q.push_back(32'd2);
    rdr(ad(1'b1, REG_STATUS), got);
    exp_v = sb_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL reload_w1c_at_expiry: got %0d want %0d", got, exp_v); end
    rdr(ad(1'b1, REG_COUNT), got);
    exp_v = sb_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL reload_count_after_expiry: got %0d want %0d", got, exp_v); end
    // Edge 4 is mid-period: the clear takes effect, IRQ falls one cycle later.
    wr(ad(1'b1, REG_STATUS), 32'd1);
    sb_q.push_back(32'd0); sb_q.push_back(32'd1);
    rdr(ad(1'b1, REG_STATUS), got);
    exp_v = sb_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL reload_w1c_mid: got %0d want %0d", got, exp_v); end
    exp_v = sb_q.pop_front(); checks++;
    if ({31'd0, irq} !== exp_v) begin errors++; $display("FAIL reload_irq_before_fall: got %0d want %0d", irq, exp_v); end
    step();
    sb_q.push_back(32'd0); sb_q.push_back(32'd1);
    exp_v = sb_q.pop_front(); checks++;
    if ({30'd0, irq, irq_vec[1]} !== exp_v) begin errors++; $display("FAIL reload_irq_fall: got %b%b want 00", irq, irq_vec[1]); end
    rdr(ad(1'b1, REG_STATUS), got);
    exp_v = sb_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL reload_pend_reset_next_period: got %0d want %0d", got, exp_v); end
    step();
    sb_q.push_back(32'd1);
    exp_v = sb_q.pop_front(); checks++;
    if ({31'd0, irq} !== exp_v) begin errors++; $display("FAIL reload_irq_rise_again: got %0d want %0d", irq, exp_v); end
    wr(ad(1'b1, REG_CTRL), 32'd0);
    step();
    wr(ad(1'b1, REG_STATUS), 32'd1);
  endtask

  task automatic test_independence();
    logic [31:0] got, exp_v;
    wr(ad(1'b0, REG_PRESET), 32'd5);
    wr(ad(1'b0, REG_CTRL), 32'h1);
    for (int k = 1; k <= 6; k++) begin
      addr = ad(1'b1, REG_PRESET); wd = $urandom; we = 1'b1;
      step();
      we = 1'b0;
      sb_q.push_back((k <= 5) ? 32'(6 - k) : 32'd0);
      rdr(ad(1'b0, REG_COUNT), got);
      exp_v = sb_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL indep_count k%0d: got %0d want %0d", k, got, exp_v); end
    end
    wr(ad(1'b0, REG_STATUS), 32'd1);
    wr(ad(1'b0, REG_PRESET), 32'd4);
    wr(ad(1'b0, REG_CTRL), 32'h1);
    for (int k = 1; k <= 6; k++) begin
      if (k == 3) wr(ad(1'b0, REG_CTRL), 32'h1);
      else        step();
      case (k)
        1:       sb_q.push_back(32'd4);
        2, 3:    sb_q.push_back(32'd3);
        4:       sb_q.push_back(32'd2);
        5:       sb_q.push_back(32'd1);
        default: sb_q.push_back(32'd0);
      endcase
      rdr(ad(1'b0, REG_COUNT), got);
      exp_v = sb_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL freeze_count k%0d: got %0d want %0d", k, got, exp_v); end
    end
    wr(ad(1'b0, REG_STATUS), 32'd1);
  endtask

  task automatic test_edge_cases();
    logic [31:0] got, exp_v;
    wr(ad(1'b0, REG_PRESET), 32'd0);
    wr(ad(1'b0, REG_CTRL), 32'h1);
    step();
    sb_q.push_back(32'd0);
    rdr(ad(1'b0, REG_STATUS), got);
    exp_v = sb_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL preset0_pend_at_load: got %0d want %0d", got, exp_v); end
    step();
    sb_q.push_back(32'd1);
    rdr(ad(1'b0, REG_STATUS), got);
    exp_v = sb_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL preset0_pend_first_tick: got %0d want %0d", got, exp_v); end
    step();
    sb_q.push_back(32'd0);
    exp_v = sb_q.pop_front(); checks++;
    if ({30'd0, irq, irq_vec[0]} !== exp_v) begin errors++; $display("FAIL ie0_irq: got %b%b want 00", irq, irq_vec[0]); end
    wr(ad(1'b0, REG_CTRL), 32'h8);
    step();
    sb_q.push_back(32'd1);
    exp_v = sb_q.pop_front(); checks++;
    if ({31'd0, irq} !== exp_v) begin errors++; $display("FAIL ie_set_irq: got %0d want %0d", irq, exp_v); end
    wr(ad(1'b0, REG_CTRL), 32'h0);
    step();
    sb_q.push_back(32'd0); sb_q.push_back(32'd1);
    exp_v = sb_q.pop_front(); checks++;
    if ({31'd0, irq_vec[0]} !== exp_v) begin errors++; $display("FAIL ie_clear_irqvec: got %0d want %0d", irq_vec[0], exp_v); end
    rdr(ad(1'b0, REG_STATUS), got);
    exp_v = sb_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL ie_clear_pend_kept: got %0d want %0d", got, exp_v); end
    wr(ad(1'b0, REG_STATUS), 32'd1);
  endtask

  task automatic test_prescale();
    logic [31:0] got, exp_v;
    int first, j1;
    for (int d = 0; d < 4; d++) begin
      repeat (d) step();
      wr4(ad4(2'd0, REG_PRESET), 32'd2);
      wr4(ad4(2'd0, REG_CTRL), 32'h1);
      // LOAD at edge 1; the next pre-edge phase is ref_ps+1, expiry on the 2nd tick.
      j1 = (3 - ((int'(ref_ps) + 1) % 4) + 4) % 4;
      sb_q.push_back(32'(6 + j1));
      first = -1;
      for (int k = 1; k <= 12; k++) begin
        step();
        rdr4(ad4(2'd0, REG_STATUS), got);
        if (got[0] && first < 0) first = k;
      end
      exp_v = sb_q.pop_front(); checks++;
      if (32'(first) !== exp_v) begin errors++; $display("FAIL prescale_expiry_edge d%0d: got %0d want %0d", d, first, exp_v); end
      wr4(ad4(2'd0, REG_STATUS), 32'd1);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] got, exp_v;
    wr4(ad4(2'd3, REG_CTRL), 32'hF);
    wr4(ad4(2'd3, REG_PRESET), 32'd7);
    wr4(ad4(2'd2, REG_PRESET), 32'hABCD1234);
    step();
    for (int r = 0; r < 4; r++) begin
      sb_q.push_back(32'd0);
      rdr4(ad4(2'd3, r[1:0]), got);
      exp_v = sb_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL oor_read r%0d: got %0h want %0h", r, got, exp_v); end
    end
    step();
    sb_q.push_back(32'd0); sb_q.push_back(32'h1234);
    rdr4(ad4(2'd1, REG_CTRL), got);
    exp_v = sb_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL oor_no_alias: got %0h want %0h", got, exp_v); end
    rdr4(ad4(2'd2, REG_PRESET), got);
    exp_v = sb_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL preset_trunc: got %0h want %0h", got, exp_v); end
  endtask

  task automatic test_reset_midcount();
    logic [31:0] got, exp_v;
    wr(ad(1'b0, REG_PRESET), 32'd3);
    wr(ad(1'b0, REG_CTRL), 32'hB);
    repeat (5) step();
    sb_q.push_back(32'd1);
    exp_v = sb_q.pop_front(); checks++;
    if ({31'd0, irq} !== exp_v) begin errors++; $display("FAIL midrst_irq_before: got %0d want %0d", irq, exp_v); end
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    for (int r = 0; r < 4; r++) begin
      sb_q.push_back(32'd0);
      rdr(ad(1'b0, r[1:0]), got);
      exp_v = sb_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL midrst_reg r%0d: got %0h want %0h", r, got, exp_v); end
    end
    sb_q.push_back(32'd0);
    exp_v = sb_q.pop_front(); checks++;
    if ({29'd0, irq, irq_vec} !== exp_v) begin errors++; $display("FAIL midrst_irq: got %b%b want 000", irq, irq_vec); end
    repeat (3) step();
    sb_q.push_back(32'd0);
    rdr(ad(1'b0, REG_COUNT), got);
    exp_v = sb_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL midrst_count_stays: got %0h want %0h", got, exp_v); end
    checks++;
    if (dut.g_ch[0].u_ch.state_r !== IDLE) begin errors++; $display("FAIL midrst_state: got %0d want %0d", dut.g_ch[0].u_ch.state_r, IDLE); end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_independence();
    test_edge_cases();
    test_prescale();
    test_out_of_range();
    test_reset_midcount();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_timer.md
Name: multi_timer

Overview:
- Parametrised successor to the single-channel bus timer: N_CH independent down-counters behind one memory-mapped bus slave port.
- Each channel supports one-shot or auto-reload mode and has a sticky pending flag cleared by write-1-to-clear (W1C).
- Produces a per-channel interrupt vector and an OR-reduced IRQ for the CP0/interrupt controller.
- A shared prescaler divides the count rate.

Parameters:
- N_CH, 2, number of timer channels (1..8).
- CNT_W, 32, counter/preset width (8..32); registers are zero-extended to 32 bits on read.
- PRESCALE, 1, clock cycles per count tick (>=1); 1 means a tick every cycle.

Ports:
- CLK  in  1  system clock, rising-edge.
- RST_N  in  1  synchronous active-low reset, sampled on the CLK rising edge.
- ADDR  in  CH_W+2  word address {channel, reg}; CH_W = max(1, clog2(N_CH)); reg: 0 CTRL, 1 PRESET, 2 COUNT, 3 STATUS.
- WE  in  1  write enable.
- WD  in  32  write data.
- RD  out  32  combinational read data for ADDR.
- IRQ  out  1  registered OR of IRQ_VEC.
- IRQ_VEC  out  N_CH  per-channel registered interrupt = PEND & IE.

Behaviour:
- Reset (RST_N=0 at an edge): all CTRL, PRESET, COUNT, PEND, prescaler and state cleared; IRQ=0; IRQ_VEC=0; all channels IDLE. Reset overrides everything, including mid-count.
- Register fields:
  - CTRL[0] EN, CTRL[1] MODE (0 one-shot, 1 auto-reload), CTRL[3] IE. Other bits write-ignored, read 0.
  - PRESET: a write takes WD[CNT_W-1:0].
  - COUNT: read-only; writes ignored.
  - STATUS[0] PEND: writing 1 clears it; writing 0 has no effect.
- Address decode: a channel index >= N_CH reads 0 and ignores writes.
- Prescaler: free-running 0..PRESCALE-1, shared by all channels. tick=1 in the cycle it equals PRESCALE-1. It is not reset by bus writes.
- Per-channel FSM:
  - IDLE: if EN=1 -> LOAD.
  - LOAD (one cycle, independent of tick): COUNT<=PRESET -> CNT.
  - CNT: if EN=0 -> IDLE, COUNT holds. Otherwise, on tick:
    - COUNT>1: COUNT<=COUNT-1.
    - COUNT<=1 (expiry): COUNT<=0, PEND<=1. Then MODE=0: EN<=0 -> IDLE. MODE=1: COUNT<=PRESET, stay CNT.
- PRESET=0 behaves as PRESET=1: expiry on the first tick after LOAD.
- Latency: the EN write edge is edge 0. LOAD happens at edge 1. With PRESCALE=1 and PRESET=P, PEND sets at edge P+1. IRQ_VEC rises at edge P+2; IRQ rises in the same cycle (same registered stage, not a further stage).
- Auto-reload period is exactly P ticks.
- Bus write to a channel's CTRL or PRESET in the same cycle as that channel's FSM update:
  - The write wins; that channel's FSM and COUNT hold for the cycle.
  - Other channels are unaffected.
- A PRESET write while in CNT does not alter COUNT until the next reload.
- STATUS W1C in the same cycle as expiry: set wins, so PEND stays 1.
- A CTRL write with EN=1 while in CNT does not restart the count. Restart requires EN=0, then EN=1.
- Clearing IE drops IRQ_VEC the next cycle; PEND is retained and re-raises IRQ if IE is set again.
- COUNT wrap-around is impossible: it never decrements below 0.

Decomposition:
- multi_timer_pkg:
  - Register offset constants: REG_CTRL, REG_PRESET, REG_COUNT, REG_STATUS.
  - CTRL bit indices: EN, MODE, IE.
  - Channel state enum: IDLE, LOAD, CNT.
- Sub-module timer_channel (CNT_W):
  - Inputs: tick, per-channel write strobes, WD.
  - Outputs: CTRL/PRESET/COUNT/PEND values and irq.
- The top instantiates N_CH channels, the shared prescaler, the address decode, the RD mux and the IRQ OR.

Test Plan:
- One-shot, PRESCALE=1, ch0 PRESET=3, CTRL=0x9 -> PEND=1 at edge 4, IRQ_VEC[0]=1 and IRQ=1 at edge 5, CTRL reads 0x8, COUNT reads 0, FSM IDLE.
- Auto-reload, ch1 PRESET=2, CTRL=0xB -> PEND set every 2 ticks. W1C STATUS=1 written in an expiry cycle leaves PEND=1; written mid-period, it clears PEND and IRQ falls the next cycle.
- PRESCALE=4, PRESET=2, one-shot -> expiry on the 2nd tick after LOAD, i.e. a count phase of 5..8 cycles depending on prescaler phase. The bench checks the exact cycle against a reference tick model.
- Channel independence: ch0 counting while the bus writes ch1 PRESET every cycle -> ch0 COUNT sequence unchanged. A write to ch0 CTRL freezes ch0 for exactly one cycle.
- Edge cases: PRESET=0 -> expiry one tick after LOAD. IE=0 at expiry -> PEND=1, IRQ=0; setting IE later -> IRQ=1 the next cycle. An out-of-range channel address reads 0 and writes are ignored.
- RST_N=0 for one cycle mid-count with PEND=1 -> all registers 0, IRQ=0, and the channel stays IDLE until EN is rewritten.
